alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one N-bit ALU between two requesters, for example a fetch/compare unit and a display/monitor path.
- Arbitrates round-robin and captures the winning requester's operands into registers that drive the ALU inputs.
- Waits a programmable ALU latency, then returns the result and carry to the owner over a valid/ready response handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays combinational or pipelined outside this block.

Parameters:
- N, 32, operand/result width.
- ALU_LAT, 1, cycles from operands stable to result sampled; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req0_i / req1_i  in  1  request from requester 0 / 1.
- a0_i, b0_i / a1_i, b1_i  in  N  operands of requester 0 / 1.
- op0_i / op1_i  in  4  ALU operation code.
- inv0_i / inv1_i  in  1  invert-B control.
- cin0_i / cin1_i  in  1  carry-in.
- gnt0_o / gnt1_o  out  1  one-cycle grant; operands are sampled on this edge.
- rsp_valid0_o / rsp_valid1_o  out  1  response valid to owner.
- rsp_ready0_i / rsp_ready1_i  in  1  owner accepts response.
- rsp_data_o  out  N  result; shared by both requesters, qualified by rsp_validX_o.
- rsp_carry_o  out  1  carry-out, qualified the same way.
- alu_a_o, alu_b_o  out  N  registered operands to the ALU.
- alu_op_o  out  4  registered operation to the ALU.
- alu_inv_o, alu_cin_o  out  1  registered invert / carry-in.
- alu_result_i  in  N  ALU result.
- alu_cout_i  in  1  ALU carry-out.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state = IDLE; owner = 0.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
  - Reset mid-operation aborts it: no response is issued and no grant is held.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one reqX_i is high, grant X; if both are high, grant the requester that is not last.
  - gntX_o is asserted combinationally in the same cycle as the grant.
  - On the next edge: load a/b/op/inv/cin of X into the alu_* registers, set owner = X, clear the latency counter, go to EXEC.
  - If no request is high, stay in IDLE and hold the alu_* outputs at their previous values.
- Requester rules:
  - A requester holds reqX_i and its operands until it sees gntX_o.
  - Dropping reqX_i before a grant withdraws the request with no side effects.
- EXEC:
  - alu_* outputs are held stable.
  - The counter increments each cycle.
  - When the counter equals ALU_LAT-1: capture alu_result_i → rsp_data_o and alu_cout_i → rsp_carry_o, go to RESP.
  - EXEC therefore lasts exactly ALU_LAT cycles.
- RESP:
  - rsp_valid<owner>_o = 1; the other valid stays 0.
  - rsp_data_o and rsp_carry_o are held until rsp_ready<owner>_i = 1 on an edge.
  - On that edge: deassert valid, set last = owner, go to IDLE.
  - The non-owner's ready is ignored.
- Timing: no new grant is issued in EXEC or RESP. Minimum spacing between grants is ALU_LAT+2 cycles.
- Fairness: if both requesters are held high continuously, grants alternate 0,1,0,1,…
- Width rule: results are passed through unmodified at N bits; no extension or truncation.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt_cnt0_o and gnt_cnt1_o, each 16 bits.
  - Each counter increments on every grant to its requester and wraps 0xFFFF → 0x0000.
  - Both counters reset to 0 by rst_ni.
  - Adds input stats_clr_i: synchronous clear of both counters. If stats_clr_i coincides with a grant, the clear wins (counter = 0).
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then single request:
  - Stimulus: rst_ni low 3 cycles, release; req0 with a0=0x0000_0005, b0=0x0000_0003, op0=add, ALU_LAT=1, rsp_ready0 held 1.
  - Required: gnt0 for 1 cycle; rsp_valid0 asserted 2 cycles after gnt0 with rsp_data=0x0000_0008; busy_o drops the cycle after acceptance.
- Simultaneous requests:
  - Stimulus: req0 and req1 held high for 4 transactions.
  - Required: grant order 0,1,0,1; each response goes only to its owner with that owner's operands.
- Response backpressure:
  - Stimulus: rsp_ready1 held low for 5 cycles in RESP.
  - Required: rsp_valid1 and rsp_data stay stable; no gnt0 during the stall although req0 is high; gnt0 follows acceptance.
- Latency sweep:
  - Stimulus: ALU_LAT=3; ALU model drives the result only 3 cycles after its inputs change.
  - Required: correct result captured; gnt-to-valid spacing = 4 cycles.
- Reset mid-operation:
  - Stimulus: assert rst_ni during EXEC.
  - Required: all outputs 0 asynchronously, no response after release, and a new req1 is granted normally.
- Stats counters (ALU_ARB_STATS_EN defined):
  - Stimulus: 3 grants to requester 0, 1 to requester 1, then stats_clr_i.
  - Required: counters read 3 and 1, then 0 and 0.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_rr_arbiter                                                |
// | Brief    : Round-robin arbiter sharing one ALU between two requesters,   |
// |            with operand capture, latency wait and valid/ready response.  |
// |            Optional grant statistics enabled by ALU_ARB_STATS_EN.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module alu_rr_arbiter #(
  parameter int N       = 32,
  parameter int ALU_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_i,
  input  logic         req1_i,
  input  logic [N-1:0] a0_i,
  input  logic [N-1:0] b0_i,
  input  logic [N-1:0] a1_i,
  input  logic [N-1:0] b1_i,
  input  logic [3:0]   op0_i,
  input  logic [3:0]   op1_i,
  input  logic         inv0_i,
  input  logic         inv1_i,
  input  logic         cin0_i,
  input  logic         cin1_i,
  output logic         gnt0_o,
  output logic         gnt1_o,
  output logic         rsp_valid0_o,
  output logic         rsp_valid1_o,
  input  logic         rsp_ready0_i,
  input  logic         rsp_ready1_i,
  output logic [N-1:0] rsp_data_o,
  output logic         rsp_carry_o,
  output logic [N-1:0] alu_a_o,
  output logic [N-1:0] alu_b_o,
  output logic [3:0]   alu_op_o,
  output logic         alu_inv_o,
  output logic         alu_cin_o,
  input  logic [N-1:0] alu_result_i,
  input  logic         alu_cout_i,
  output logic         busy_o
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic         stats_clr_i,
  output logic [15:0]  gnt_cnt0_o,
  output logic [15:0]  gnt_cnt1_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_lat_last = 4'(ALU_LAT - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_owner;
  logic         r_last;
  logic [3:0]   r_lat_cnt;
  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [3:0]   r_alu_op;
  logic         r_alu_inv;
  logic         r_alu_cin;
  logic [N-1:0] r_rsp_data;
  logic         r_rsp_carry;
  logic         w_gnt0;
  logic         w_gnt1;
  logic         w_owner_rdy;

  // On a tie the requester that was not served last wins.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE) begin
      if (req0_i && (!req1_i || r_last))
        w_gnt0 = 1'b1;
      else if (req1_i)
        w_gnt1 = 1'b1;
    end
  end

  assign w_owner_rdy = r_owner ? rsp_ready1_i : rsp_ready0_i;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_gnt0 || w_gnt1) w_state_nxt = S_EXEC;
      S_EXEC:  if (r_lat_cnt == c_lat_last) w_state_nxt = S_RESP;
      S_RESP:  if (w_owner_rdy) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_lat_cnt   <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_inv   <= 1'b0;
      r_alu_cin   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_alu_a   <= w_gnt1 ? a1_i   : a0_i;
            r_alu_b   <= w_gnt1 ? b1_i   : b0_i;
            r_alu_op  <= w_gnt1 ? op1_i  : op0_i;
            r_alu_inv <= w_gnt1 ? inv1_i : inv0_i;
            r_alu_cin <= w_gnt1 ? cin1_i : cin0_i;
            r_owner   <= w_gnt1;
            r_lat_cnt <= '0;
          end
        end
        S_EXEC: begin
          r_lat_cnt <= r_lat_cnt + 4'd1;
          if (r_lat_cnt == c_lat_last) begin
            r_rsp_data  <= alu_result_i;
            r_rsp_carry <= alu_cout_i;
          end
        end
        S_RESP: begin
          if (w_owner_rdy) r_last <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // Grants are combinational, so gate them with reset to keep outputs low.
  assign gnt0_o       = w_gnt0 & rst_ni;
  assign gnt1_o       = w_gnt1 & rst_ni;
  assign rsp_valid0_o = (r_state == S_RESP) && !r_owner;
  assign rsp_valid1_o = (r_state == S_RESP) && r_owner;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_carry_o  = r_rsp_carry;
  assign alu_a_o      = r_alu_a;
  assign alu_b_o      = r_alu_b;
  assign alu_op_o     = r_alu_op;
  assign alu_inv_o    = r_alu_inv;
  assign alu_cin_o    = r_alu_cin;
  assign busy_o       = (r_state != S_IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else if (stats_clr_i) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_gnt0) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      if (w_gnt1) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0_o = r_gnt_cnt0;
  assign gnt_cnt1_o = r_gnt_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_rr_arbiter                                             |
// | Brief    : Scoreboard bench for alu_rr_arbiter (ALU_LAT=1 and =3 DUTs).   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_alu_rr_arbiter;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Requester side of the ALU_LAT=1 instance
  logic         req[2];
  logic [N-1:0] a[2], b[2];
  logic [3:0]   op[2];
  logic         inv[2], cin[2], rr[2];
  logic         gnt[2], rv[2];
  logic [N-1:0] rdata, alu_a, alu_b, alu_res;
  logic [3:0]   alu_op;
  logic         rcarry, alu_inv, alu_cin, alu_cout, busy;
  logic         stats_clr = 1'b0;
  logic [15:0]  cnt0, cnt1;

  // ALU_LAT=3 instance, only requester 0 used
  logic         req3, inv3, cin3, rr3;
  logic [N-1:0] a3, b3, rdata3, alu_a3, alu_b3, alu_res3;
  logic [3:0]   op3, alu_op3;
  logic         gnt3, gnt3_1, rv3, rv3_1, rcarry3, alu_inv3, alu_cin3, alu_cout3, busy3;
  logic [15:0]  cnt3_0, cnt3_1;

  logic [N:0]   q0[$], q1[$], q3[$];
  int           gnt_log[$];

  function automatic logic [N:0] alu_f(input logic [N-1:0] fa, input logic [N-1:0] fb,
                                        input logic [3:0] fop, input logic finv, input logic fcin);
    logic [N-1:0] bb;
    logic [N:0]   r;
    bb = finv ? ~fb : fb;
    case (fop)
      4'd0:    r = {1'b0, fa} + {1'b0, bb} + {{N{1'b0}}, fcin};
      4'd1:    r = {1'b0, fa & bb};
      4'd2:    r = {1'b0, fa | bb};
      4'd3:    r = {1'b0, fa ^ bb};
      default: r = {1'b0, fa};
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_res} = alu_f(alu_a, alu_b, alu_op, alu_inv, alu_cin);

  // Result becomes valid on the third edge after the operands change
  logic [N:0] p1, p2;
  always @(posedge clk) begin
    p1 <= alu_f(alu_a3, alu_b3, alu_op3, alu_inv3, alu_cin3);
    p2 <= p1;
  end
  assign {alu_cout3, alu_res3} = p2;

  alu_rr_arbiter #(.N(N), .ALU_LAT(1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req[0]), .req1_i(req[1]),
    .a0_i(a[0]), .b0_i(b[0]), .a1_i(a[1]), .b1_i(b[1]),
    .op0_i(op[0]), .op1_i(op[1]), .inv0_i(inv[0]), .inv1_i(inv[1]),
    .cin0_i(cin[0]), .cin1_i(cin[1]),
    .gnt0_o(gnt[0]), .gnt1_o(gnt[1]),
    .rsp_valid0_o(rv[0]), .rsp_valid1_o(rv[1]),
    .rsp_ready0_i(rr[0]), .rsp_ready1_i(rr[1]),
    .rsp_data_o(rdata), .rsp_carry_o(rcarry),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
    .alu_inv_o(alu_inv), .alu_cin_o(alu_cin),
    .alu_result_i(alu_res), .alu_cout_i(alu_cout),
    .busy_o(busy)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr_i(stats_clr), .gnt_cnt0_o(cnt0), .gnt_cnt1_o(cnt1)
`endif
  );

  alu_rr_arbiter #(.N(N), .ALU_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req3), .req1_i(1'b0),
    .a0_i(a3), .b0_i(b3), .a1_i('0), .b1_i('0),
    .op0_i(op3), .op1_i(4'd0), .inv0_i(inv3), .inv1_i(1'b0),
    .cin0_i(cin3), .cin1_i(1'b0),
    .gnt0_o(gnt3), .gnt1_o(gnt3_1),
    .rsp_valid0_o(rv3), .rsp_valid1_o(rv3_1),
    .rsp_ready0_i(rr3), .rsp_ready1_i(1'b1),
    .rsp_data_o(rdata3), .rsp_carry_o(rcarry3),
    .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_op_o(alu_op3),
    .alu_inv_o(alu_inv3), .alu_cin_o(alu_cin3),
    .alu_result_i(alu_res3), .alu_cout_i(alu_cout3),
    .busy_o(busy3)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr_i(1'b0), .gnt_cnt0_o(cnt3_0), .gnt_cnt1_o(cnt3_1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: pop the owner's expected result on every accepted response
  always @(negedge clk) begin
    logic [N:0] e;
    if (rst_n) begin
      if (rv[0] | rv[1]) check_val("one_valid", 64'(rv[0] & rv[1]), 64'd0);
      if (rv[0] && rr[0]) begin
        if (q0.size() == 0) check_val("rsp0_spurious", 64'(rv[0]), 64'd0);
        else begin
          e = q0.pop_front();
          check_val("rsp0_data", 64'(rdata), 64'(e[N-1:0]));
          check_val("rsp0_carry", 64'(rcarry), 64'(e[N]));
        end
      end
      if (rv[1] && rr[1]) begin
        if (q1.size() == 0) check_val("rsp1_spurious", 64'(rv[1]), 64'd0);
        else begin
          e = q1.pop_front();
          check_val("rsp1_data", 64'(rdata), 64'(e[N-1:0]));
          check_val("rsp1_carry", 64'(rcarry), 64'(e[N]));
        end
      end
      if (rv3 && rr3) begin
        if (q3.size() == 0) check_val("rsp3_spurious", 64'(rv3), 64'd0);
        else begin
          e = q3.pop_front();
          check_val("rsp3_data", 64'(rdata3), 64'(e[N-1:0]));
          check_val("rsp3_carry", 64'(rcarry3), 64'(e[N]));
        end
      end
      if (gnt[0]) gnt_log.push_back(0);
      if (gnt[1]) gnt_log.push_back(1);
    end
  end

  // Called and returns at posedge+1; holds the request until granted
  task automatic send(input int id, input logic [N-1:0] av, input logic [N-1:0] bv,
                      input logic [3:0] opv, input logic invv, input logic cinv);
    int t = 0;
    req[id] = 1'b1; a[id] = av; b[id] = bv; op[id] = opv; inv[id] = invv; cin[id] = cinv;
    if (id == 0) q0.push_back(alu_f(av, bv, opv, invv, cinv));
    else         q1.push_back(alu_f(av, bv, opv, invv, cinv));
    do begin @(negedge clk); t++; end while (!gnt[id] && t < 50);
    check_val($sformatf("gnt%0d_seen", id), 64'(gnt[id]), 64'd1);
    @(posedge clk); #1;
    req[id] = 1'b0; a[id] = $urandom; b[id] = $urandom; op[id] = 4'($urandom_range(0, 3));
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || q3.size() != 0 || busy || busy3) && t < 200) begin
      @(negedge clk); t++;
    end
    check_val("drain_done", 64'(t < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int g;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; a[i] = '0; b[i] = '0; op[i] = '0; inv[i] = 0; cin[i] = 0; rr[i] = 1;
    end
    req3 = 0; a3 = '0; b3 = '0; op3 = '0; inv3 = 0; cin3 = 0; rr3 = 1;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctrl", 64'({gnt[0], gnt[1], rv[0], rv[1], busy, rcarry, alu_inv, alu_cin}), 64'd0);
    check_val("rst_data", 64'(rdata), 64'd0);
    check_val("rst_alu", 64'({alu_a, alu_op}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request with exact timing
    req[0] = 1; a[0] = 32'h5; b[0] = 32'h3; op[0] = 4'd0;
    q0.push_back(alu_f(32'h5, 32'h3, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    check_val("t1_gnt0", 64'({gnt[0], gnt[1], busy}), 64'b100);
    @(posedge clk); #1; req[0] = 0;
    @(negedge clk);
    check_val("t1_exec", 64'({gnt[0], busy, rv[0]}), 64'b010);
    check_val("t1_alu_ab", 64'({alu_a, alu_b}), {32'h5, 32'h3});
    @(negedge clk);
    check_val("t1_valid", 64'({rv[0], rv[1], busy}), 64'b101);
    check_val("t1_data", 64'(rdata), 64'h8);
    @(negedge clk);
    check_val("t1_idle", 64'({busy, rv[0]}), 64'b00);
    @(posedge clk); #1;

    // More operand patterns: carry out, subtract via invert+carry-in, AND
    send(0, 32'hFFFF_FFFF, 32'h1, 4'd0, 1'b0, 1'b0);
    send(1, 32'd10, 32'd3, 4'd0, 1'b1, 1'b1);
    send(0, 32'h0000_F0F0, 32'h0000_FF00, 4'd1, 1'b0, 1'b0);
    drain();

    // Simultaneous requests alternate starting with requester 0
    pulse_reset();
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, 32'h100 + 32'(i), 32'h1000, 4'd0, 1'b0, 1'b0);
      end
      begin
        for (int j = 0; j < 4; j++) send(1, 32'h2000_0000 + 32'(j), 32'h0F, 4'd3, 1'b0, 1'b0);
      end
    join
    drain();
    check_val("rr_gnt_count", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size() && i < 8; i++)
      check_val($sformatf("rr_order%0d", i), 64'(gnt_log[i]), 64'(i % 2));

    // Backpressure on requester 1 while requester 0 waits
    rr[1] = 0;
    req[1] = 1; a[1] = 32'hAAAA_0000; b[1] = 32'h0000_5555; op[1] = 4'd2;
    q1.push_back(alu_f(32'hAAAA_0000, 32'h0000_5555, 4'd2, 1'b0, 1'b0));
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt[1] && t < 50);
    check_val("bp_gnt1", 64'(gnt[1]), 64'd1);
    @(posedge clk); #1; req[1] = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!rv[1] && t < 50);
    check_val("bp_valid1", 64'(rv[1]), 64'd1);
    req[0] = 1; a[0] = 32'h3; b[0] = 32'h4; op[0] = 4'd3;
    q0.push_back(alu_f(32'h3, 32'h4, 4'd3, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_val("bp_stall", 64'({rv[1], rv[0], gnt[0], busy}), 64'b1001);
      check_val("bp_data", 64'(rdata), 64'hAAAA_5555);
    end
    @(posedge clk); #1; rr[1] = 1;
    @(negedge clk);
    check_val("bp_no_gnt_yet", 64'(gnt[0]), 64'd0);
    @(negedge clk);
    check_val("bp_gnt0_after", 64'(gnt[0]), 64'd1);
    @(posedge clk); #1; req[0] = 0;
    drain();

    // Latency sweep on the ALU_LAT=3 instance
    for (int k = 0; k < 2; k++) begin
      a3 = (k == 0) ? 32'd7 : 32'hF0;
      b3 = (k == 0) ? 32'd9 : 32'h0F;
      op3 = (k == 0) ? 4'd0 : 4'd2;
      req3 = 1;
      q3.push_back(alu_f(a3, b3, op3, 1'b0, 1'b0));
      t = 0;
      do begin @(negedge clk); t++; end while (!gnt3 && t < 50);
      check_val("lat_gnt", 64'(gnt3), 64'd1);
      g = cyc;
      @(posedge clk); #1;
      req3 = 0; a3 = $urandom; b3 = $urandom;
      t = 0;
      do begin @(negedge clk); t++; end while (!rv3 && t < 50);
      check_val("lat_spacing", 64'(cyc - g), 64'd4);
      drain();
    end

    // Reset during EXEC aborts the transaction
    req[0] = 1; a[0] = 32'h1234; b[0] = 32'h1; op[0] = 4'd0;
    @(negedge clk);
    check_val("mr_gnt0", 64'(gnt[0]), 64'd1);
    @(posedge clk); #1; req[0] = 0;
    #2 rst_n = 1'b0;
    #1;
    check_val("mr_ctrl", 64'({gnt[0], gnt[1], rv[0], rv[1], busy, rcarry}), 64'd0);
    check_val("mr_data", 64'(rdata), 64'd0);
    check_val("mr_alu", 64'({alu_a, alu_b}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("mr_no_rsp", 64'({rv[0], rv[1], busy}), 64'd0);
    end
    @(posedge clk); #1;
    send(1, 32'h0000_0040, 32'h0000_0002, 4'd0, 1'b0, 1'b1);
    drain();

`ifdef ALU_ARB_STATS_EN
    // Grant counters and clear-over-grant priority
    pulse_reset();
    for (int k = 0; k < 3; k++) send(0, 32'(k), 32'd1, 4'd0, 1'b0, 1'b0);
    send(1, 32'd9, 32'd9, 4'd1, 1'b0, 1'b0);
    drain();
    check_val("stats_cnt0", 64'(cnt0), 64'd3);
    check_val("stats_cnt1", 64'(cnt1), 64'd1);
    req[0] = 1; a[0] = 32'd2; b[0] = 32'd2; op[0] = 4'd0; stats_clr = 1;
    q0.push_back(alu_f(32'd2, 32'd2, 4'd0, 1'b0, 1'b0));
    @(negedge clk);
    check_val("stats_clr_gnt", 64'(gnt[0]), 64'd1);
    @(posedge clk); #1; req[0] = 0; stats_clr = 0;
    @(negedge clk);
    check_val("stats_clr_cnt", 64'({cnt0, cnt1}), 64'd0);
    drain();
`endif

    check_val("q_left", 64'(q0.size() + q1.size() + q3.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
